// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: FSM states, RV32I funct3 codes,
// byte-lane masks and load extension.
package lsu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD0  = 3'd1,
        ST_RD1  = 3'd2,
        ST_WR0  = 3'd3,
        ST_WR1  = 3'd4,
        ST_RESP = 3'd5
    } lsu_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    function automatic logic [3:0] lane_mask(input logic [2:0] funct3);
        logic [3:0] m;
        case (funct3[1:0])
            2'b00:   m = 4'b0001;
            2'b01:   m = 4'b0011;
            2'b10:   m = 4'b1111;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

    function automatic logic [2:0] access_size(input logic [2:0] funct3);
        logic [2:0] s;
        case (funct3[1:0])
            2'b00:   s = 3'd1;
            2'b01:   s = 3'd2;
            default: s = 3'd4;
        endcase
        return s;
    endfunction

    function automatic logic [31:0] extend_load(input logic [31:0] raw, input logic [2:0] funct3);
        logic [31:0] r;
        case (funct3)
            F3_B:    r = {{24{raw[7]}}, raw[7:0]};
            F3_H:    r = {{16{raw[15]}}, raw[15:0]};
            F3_W:    r = raw;
            F3_BU:   r = {24'h000000, raw[7:0]};
            F3_HU:   r = {16'h0000, raw[15:0]};
            default: r = 32'h00000000;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational byte steering: merges store bytes into captured memory words and extracts
// and extends load data. Second-word paths exist only when LSU_MISALIGNED_EN is defined.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] wdata,
    input  logic [31:0] buf0,
`ifdef LSU_MISALIGNED_EN
    input  logic [31:0] buf1,
    output logic [31:0] merge1,
`endif
    output logic [31:0] merge0,
    output logic [31:0] load_data
);

`ifdef LSU_MISALIGNED_EN
    localparam int LANES = 8;
`else
    localparam int LANES = 4;
`endif
    localparam int DW = 8 * LANES;

    logic [DW-1:0]    data_s;
    logic [LANES-1:0] mask_s;

    // Position store bytes and their lane mask at the byte offset, then merge over old data
    always_comb begin
        data_s = DW'(wdata) << {offset, 3'b000};
        mask_s = LANES'(lane_mask(funct3)) << offset;
        merge0 = buf0;
        for (int i = 0; i < 4; i++) begin
            merge0[8*i +: 8] = mask_s[i] ? data_s[8*i +: 8] : buf0[8*i +: 8];
        end
`ifdef LSU_MISALIGNED_EN
        merge1 = buf1;
        for (int i = 0; i < 4; i++) begin
            merge1[8*i +: 8] = mask_s[i+4] ? data_s[8*(i+4) +: 8] : buf1[8*i +: 8];
        end
        load_data = extend_load(32'({buf1, buf0} >> {offset, 3'b000}), funct3);
`else
        load_data = extend_load(buf0 >> {offset, 3'b000}, funct3);
`endif
    end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit over a word-granular memory; sub-word stores use read-modify-write.
// Define LSU_MISALIGNED_EN to split word-crossing H/W accesses instead of faulting them.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned MEM_BYTES = 65536
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_fault,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd
);

    lsu_state_e  state_r;
    logic        we_r;
    logic [2:0]  funct3_r;
    logic [1:0]  offset_r;
    logic [31:0] wdata_r;
    logic [31:0] buf0_r;
`ifdef LSU_MISALIGNED_EN
    logic        cross_r;
    logic [31:0] w1_r;
    logic [31:0] merge1_s;
`endif

    logic [2:0]  size_s;
    logic [32:0] last_byte_s;
    logic        illegal_s;
    logic        range_fault_s;
    logic        misaligned_s;
    logic        crossing_s;
    logic        fault_s;
    logic [31:0] align_buf0_s;
    logic [31:0] merge0_s;
    logic [31:0] load_data_s;

    // Request classification, evaluated on the incoming request at accept time
    always_comb begin
        size_s        = access_size(req_funct3);
        last_byte_s   = {1'b0, req_addr} + {30'h00000000, size_s - 3'd1};
        range_fault_s = (last_byte_s >= 33'(MEM_BYTES));
        case (req_funct3)
            F3_B, F3_H, F3_W: illegal_s = 1'b0;
            F3_BU, F3_HU:     illegal_s = req_we;
            default:          illegal_s = 1'b1;
        endcase
        misaligned_s = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                       ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
        crossing_s   = (({1'b0, req_addr[1:0]} + size_s) > 3'd4);
`ifdef LSU_MISALIGNED_EN
        fault_s = illegal_s || range_fault_s;
`else
        fault_s = illegal_s || range_fault_s || misaligned_s;
`endif
    end

    // In RD0 the first word is still on mem_rd; later states use the captured copy
    always_comb begin
        if (state_r == ST_RD0) begin
            align_buf0_s = mem_rd;
        end else begin
            align_buf0_s = buf0_r;
        end
    end

    lsu_align u_align (
        .funct3    (funct3_r),
        .offset    (offset_r),
        .wdata     (wdata_r),
        .buf0      (align_buf0_s),
`ifdef LSU_MISALIGNED_EN
        .buf1      (mem_rd),
        .merge1    (merge1_s),
`endif
        .merge0    (merge0_s),
        .load_data (load_data_s)
    );

    // Access sequencer; every output is registered and held for the whole state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            we_r       <= 1'b0;
            funct3_r   <= 3'b000;
            offset_r   <= 2'b00;
            wdata_r    <= 32'h00000000;
            buf0_r     <= 32'h00000000;
`ifdef LSU_MISALIGNED_EN
            cross_r    <= 1'b0;
            w1_r       <= 32'h00000000;
`endif
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= 32'h00000000;
            resp_fault <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= 32'h00000000;
            mem_wd     <= 32'h00000000;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (req_valid) begin
                        we_r      <= req_we;
                        funct3_r  <= req_funct3;
                        offset_r  <= req_addr[1:0];
                        wdata_r   <= req_wdata;
                        req_ready <= 1'b0;
`ifdef LSU_MISALIGNED_EN
                        cross_r   <= crossing_s;
                        w1_r      <= {req_addr[31:2], 2'b00} + 32'd4;
`endif
                        if (fault_s) begin
                            state_r    <= ST_RESP;
                            resp_valid <= 1'b1;
                            resp_fault <= 1'b1;
                            resp_rdata <= 32'h00000000;
                        end else if (req_we && (req_funct3 == F3_W) && (req_addr[1:0] == 2'b00)) begin
                            state_r  <= ST_WR0;
                            mem_we   <= 1'b1;
                            mem_addr <= {req_addr[31:2], 2'b00};
                            mem_wd   <= req_wdata;
                        end else begin
                            state_r  <= ST_RD0;
                            mem_we   <= 1'b0;
                            mem_addr <= {req_addr[31:2], 2'b00};
                        end
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                ST_RD0: begin
                    buf0_r <= mem_rd;
                    if (we_r) begin
                        state_r <= ST_WR0;
                        mem_we  <= 1'b1;
                        mem_wd  <= merge0_s;
                    end else begin
`ifdef LSU_MISALIGNED_EN
                        if (cross_r) begin
                            state_r  <= ST_RD1;
                            mem_addr <= w1_r;
                        end else begin
                            state_r    <= ST_RESP;
                            resp_valid <= 1'b1;
                            resp_rdata <= load_data_s;
                        end
`else
                        state_r    <= ST_RESP;
                        resp_valid <= 1'b1;
                        resp_rdata <= load_data_s;
`endif
                    end
                end
                ST_WR0: begin
                    mem_we <= 1'b0;
`ifdef LSU_MISALIGNED_EN
                    if (cross_r) begin
                        state_r  <= ST_RD1;
                        mem_addr <= w1_r;
                    end else begin
                        state_r    <= ST_RESP;
                        resp_valid <= 1'b1;
                        resp_rdata <= 32'h00000000;
                    end
`else
                    state_r    <= ST_RESP;
                    resp_valid <= 1'b1;
                    resp_rdata <= 32'h00000000;
`endif
                end
`ifdef LSU_MISALIGNED_EN
                ST_RD1: begin
                    if (we_r) begin
                        state_r <= ST_WR1;
                        mem_we  <= 1'b1;
                        mem_wd  <= merge1_s;
                    end else begin
                        state_r    <= ST_RESP;
                        resp_valid <= 1'b1;
                        resp_rdata <= load_data_s;
                    end
                end
                ST_WR1: begin
                    mem_we     <= 1'b0;
                    state_r    <= ST_RESP;
                    resp_valid <= 1'b1;
                    resp_rdata <= 32'h00000000;
                end
`endif
                ST_RESP: begin
                    state_r    <= ST_IDLE;
                    resp_valid <= 1'b0;
                    resp_rdata <= 32'h00000000;
                    resp_fault <= 1'b0;
                    req_ready  <= 1'b1;
                end
                default: begin
                    state_r    <= ST_IDLE;
                    resp_valid <= 1'b0;
                    resp_fault <= 1'b0;
                    mem_we     <= 1'b0;
                    req_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: directed requests push expected responses, a monitor
// pops and compares data, fault and latency. Crossing cases run when LSU_MISALIGNED_EN is defined.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_fault;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;

    logic [31:0] mem [0:16383];
    int          cyc = 0;
    int          wr_cnt = 0;
    int          checks = 0;
    int          errors = 0;

    typedef struct {
        string       name;
        logic [31:0] rdata;
        logic        fault;
        int          lat;
        int          acc;
    } exp_t;
    exp_t sb_q[$];

    load_store_unit #(.MEM_BYTES(65536)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_fault (resp_fault),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wd     (mem_wd),
        .mem_rd     (mem_rd)
    );

    always #5 clk = ~clk;

    assign mem_rd = mem[mem_addr[15:2]];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_we) begin
            mem[mem_addr[15:2]] = mem_wd;
            wr_cnt <= wr_cnt + 1;
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: every response must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (rst_n === 1'b1 && mem_we === 1'b1) begin
            check("mem_addr aligned", {30'h0, mem_addr[1:0]}, 32'h0);
        end
        if (rst_n === 1'b1 && resp_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected resp: got rdata %h fault %b expected no response", resp_rdata, resp_fault);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check({e.name, " rdata"}, resp_rdata, e.rdata);
                check({e.name, " fault"}, {31'h0, resp_fault}, {31'h0, e.fault});
                check({e.name, " latency"}, 32'(cyc - e.acc + 1), 32'(e.lat));
            end
        end
    end

    task automatic issue(input string nm, input logic we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] er, input logic ef, input int el,
                         input bit push);
        exp_t e;
        int   n;
        n = 0;
        @(negedge clk);
        while (req_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (req_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL %s req_ready timeout: got %b expected 1", nm, req_ready);
        end
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        @(posedge clk);
        #1;
        e.name  = nm;
        e.rdata = er;
        e.fault = ef;
        e.lat   = el;
        e.acc   = cyc;
        if (push) sb_q.push_back(e);
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while ((req_ready !== 1'b1 || sb_q.size() != 0) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            checks++;
            errors++;
            $display("FAIL idle timeout: got %0d pending expected 0", sb_q.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        for (int i = 0; i < 16384; i++) mem[i] = 32'h0;
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst req_ready", {31'h0, req_ready}, 32'h1);
        check("rst resp_valid", {31'h0, resp_valid}, 32'h0);
        check("rst resp_rdata", resp_rdata, 32'h0);
        check("rst resp_fault", {31'h0, resp_fault}, 32'h0);
        check("rst mem_we", {31'h0, mem_we}, 32'h0);
        check("rst mem_addr", mem_addr, 32'h0);
        check("rst mem_wd", mem_wd, 32'h0);
        rst_n = 1'b1;

        // Aligned word store then load
        w = wr_cnt;
        issue("SW 100", 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 1'b0, 2, 1'b1);
        wait_idle();
        check("SW 100 writes", 32'(wr_cnt - w), 32'd1);
        check("SW 100 mem", mem[32'h40], 32'hDEADBEEF);
        issue("LW 100", 1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 1'b0, 2, 1'b1);
        wait_idle();

        // Byte read-modify-write
        mem[32'h40] = 32'h11223344;
        issue("SB 102", 1'b1, 3'b000, 32'h102, 32'h000000AA, 32'h0, 1'b0, 3, 1'b1);
        issue("LW 100b", 1'b0, 3'b010, 32'h100, 32'h0, 32'h11AA3344, 1'b0, 2, 1'b1);
        issue("LB 102", 1'b0, 3'b000, 32'h102, 32'h0, 32'hFFFFFFAA, 1'b0, 2, 1'b1);
        wait_idle();

        mem[32'h40] = 32'hAA113344;
        issue("LHU 102", 1'b0, 3'b101, 32'h102, 32'h0, 32'h0000AA11, 1'b0, 2, 1'b1);
        issue("LH 102", 1'b0, 3'b001, 32'h102, 32'h0, 32'hFFFFAA11, 1'b0, 2, 1'b1);
        wait_idle();

        // Byte lanes, sign/zero extension, halfword store merge
        mem[32'h80] = 32'h7F800102;
        issue("LB 200", 1'b0, 3'b000, 32'h200, 32'h0, 32'h00000002, 1'b0, 2, 1'b1);
        issue("LBU 201", 1'b0, 3'b100, 32'h201, 32'h0, 32'h00000001, 1'b0, 2, 1'b1);
        issue("LB 202", 1'b0, 3'b000, 32'h202, 32'h0, 32'hFFFFFF80, 1'b0, 2, 1'b1);
        issue("LB 203", 1'b0, 3'b000, 32'h203, 32'h0, 32'h0000007F, 1'b0, 2, 1'b1);
        issue("SH 202", 1'b1, 3'b001, 32'h202, 32'h1234BEEF, 32'h0, 1'b0, 3, 1'b1);
        issue("LW 200", 1'b0, 3'b010, 32'h200, 32'h0, 32'hBEEF0102, 1'b0, 2, 1'b1);
        wait_idle();

        // Top of memory: last legal bytes succeed, anything beyond faults
        mem[32'h3FFF] = 32'hCAFEBABE;
        issue("LW FFFC", 1'b0, 3'b010, 32'hFFFC, 32'h0, 32'hCAFEBABE, 1'b0, 2, 1'b1);
        issue("LH FFFE", 1'b0, 3'b001, 32'hFFFE, 32'h0, 32'hFFFFCAFE, 1'b0, 2, 1'b1);
        issue("LHU FFFE", 1'b0, 3'b101, 32'hFFFE, 32'h0, 32'h0000CAFE, 1'b0, 2, 1'b1);
        issue("LB FFFF", 1'b0, 3'b000, 32'hFFFF, 32'h0, 32'hFFFFFFCA, 1'b0, 2, 1'b1);
        wait_idle();

        // Faults never touch memory
        w = wr_cnt;
        issue("LD f3=011", 1'b0, 3'b011, 32'h100, 32'h0, 32'h0, 1'b1, 1, 1'b1);
        issue("SB 10000", 1'b1, 3'b000, 32'h10000, 32'h55, 32'h0, 1'b1, 1, 1'b1);
        issue("ST f3=100", 1'b1, 3'b100, 32'h100, 32'h55, 32'h0, 1'b1, 1, 1'b1);
        issue("LW FFFFFFFC", 1'b0, 3'b010, 32'hFFFFFFFC, 32'h0, 32'h0, 1'b1, 1, 1'b1);
        issue("LBU 10000", 1'b0, 3'b100, 32'h10000, 32'h0, 32'h0, 1'b1, 1, 1'b1);
        issue("LW FFFE", 1'b0, 3'b010, 32'hFFFE, 32'h0, 32'h0, 1'b1, 1, 1'b1);
        issue("ST f3=111", 1'b1, 3'b111, 32'h100, 32'h55, 32'h0, 1'b1, 1, 1'b1);
        wait_idle();
        check("fault writes", 32'(wr_cnt - w), 32'd0);

`ifdef LSU_MISALIGNED_EN
        mem[32'h40] = 32'h44332211;
        mem[32'h41] = 32'h88776655;
        issue("LW 103 split", 1'b0, 3'b010, 32'h103, 32'h0, 32'h77665544, 1'b0, 3, 1'b1);
        wait_idle();
        w = wr_cnt;
        issue("SW 103 split", 1'b1, 3'b010, 32'h103, 32'hCAFEF00D, 32'h0, 1'b0, 5, 1'b1);
        wait_idle();
        check("SW 103 writes", 32'(wr_cnt - w), 32'd2);
        check("SW 103 word0", mem[32'h40], 32'h0D332211);
        check("SW 103 word1", mem[32'h41], 32'h88CAFEF0);
        issue("LH 103 split", 1'b0, 3'b001, 32'h103, 32'h0, 32'hFFFFF00D, 1'b0, 3, 1'b1);
        wait_idle();
`else
        w = wr_cnt;
        issue("LW 103 misaligned", 1'b0, 3'b010, 32'h103, 32'h0, 32'h0, 1'b1, 1, 1'b1);
        issue("SH 101 misaligned", 1'b1, 3'b001, 32'h101, 32'h1234, 32'h0, 1'b1, 1, 1'b1);
        wait_idle();
        check("misaligned writes", 32'(wr_cnt - w), 32'd0);
`endif

        // Reset while the store write is on the bus: no response, unit returns to idle
        mem[32'h42] = 32'h55555555;
        issue("SB 109 reset", 1'b1, 3'b000, 32'h109, 32'h00000012, 32'h0, 1'b0, 3, 1'b0);
        begin
            int n;
            n = 0;
            @(negedge clk);
            while (mem_we !== 1'b1 && n < 20) begin
                @(negedge clk);
                n++;
            end
            check("reset WR0 reached", {31'h0, mem_we}, 32'h1);
        end
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst req_ready", {31'h0, req_ready}, 32'h1);
        check("midrst resp_valid", {31'h0, resp_valid}, 32'h0);
        check("midrst mem_we", {31'h0, mem_we}, 32'h0);
        check("midrst mem word", mem[32'h42], 32'h55551255);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        issue("LW 108 after rst", 1'b0, 3'b010, 32'h108, 32'h0, 32'h55551255, 1'b0, 2, 1'b1);
        wait_idle();
        check("scoreboard empty", 32'(sb_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
